sun_pll_lock_ctrl: RTL

//  Digital start-up sequencer and lock monitor for SUN_PLL, clocked by the reference clock.

---
 rtl/sun_pll_lock_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sun_pll_lock_ctrl.sv
// sun_pll_lock_ctrl
// Start-up sequencer and frequency-lock monitor for SUN_PLL, running on the
// PLL reference clock. It raises PWRUP_1V8, waits for the analog to settle,
// then counts feedback-divider toggles over fixed windows. A run of good
// windows declares LOCK; too many windows without lock declares FAIL.
module sun_pll_lock_ctrl #(
    parameter int SETTLE_CYC = 1024,
    parameter int WIN_CYC    = 256,
    parameter int EXP_CNT    = 64,
    parameter int TOL        = 2,
    parameter int LOCK_WINS  = 4,
    parameter int MAX_WINS   = 64,
    parameter int CW         = 10
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          EN,
    input  logic          FB_TGL,
    output logic          PWRUP_1V8,
    output logic          LOCK,
    output logic          FAIL,
    output logic [2:0]    STATE,
    output logic [CW-1:0] CNT_LAST
);

    // Counter widths derived from the timing parameters.
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int WW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int GW = $clog2(LOCK_WINS + 1);
    localparam int NW = $clog2(MAX_WINS + 1);

    // Good-window band; the lower edge is clamped so it never underflows.
    localparam int GOOD_LO = (EXP_CNT > TOL) ? (EXP_CNT - TOL) : 0;
    localparam int GOOD_HI = EXP_CNT + TOL;

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYC - 1);
    localparam logic [WW-1:0] WIN_END    = WW'(WIN_CYC - 1);
    localparam logic [GW-1:0] LOCK_GOAL  = GW'(LOCK_WINS);
    localparam logic [NW-1:0] WIN_LIMIT  = NW'(MAX_WINS);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_SETTLE = 3'd1,
        S_ACQ    = 3'd2,
        S_LOCKED = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;

    // Feedback toggle synchronizer: two metastability flops plus a history flop.
    logic          fb_s1;
    logic          fb_s2;
    logic          fb_s3;
    logic          fb_edge;

    // Sequencing counters.
    logic [SW-1:0] settle_cnt;
    logic [WW-1:0] win_idx;
    logic [CW-1:0] edge_cnt;
    logic [GW-1:0] good_cnt;
    logic [NW-1:0] win_cnt;

    // Per-cycle decode of the window datapath.
    logic          settle_done;
    logic          run;
    logic          win_last;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_now;
    logic          cnt_good;
    logic [GW-1:0] gc_inc;
    logic [NW-1:0] wc_inc;
    logic          lock_hit;
    logic          fail_hit;

    // Registered-output precursors, derived from the next state.
    logic          pwrup_d;
    logic          lock_d;
    logic          fail_d;

    // Bring the asynchronous feedback toggle into the CK domain.
    always_ff @(posedge CK) begin
        if (RST) begin
            fb_s1 <= 1'b0;
            fb_s2 <= 1'b0;
            fb_s3 <= 1'b0;
        end else begin
            fb_s1 <= FB_TGL;
            fb_s2 <= fb_s1;
            fb_s3 <= fb_s2;
        end
    end

    // Either polarity of the divider toggle is one feedback unit.
    assign fb_edge = fb_s2 ^ fb_s3;

    // Window arithmetic: the count seen at the end of this cycle, and its verdict.
    always_comb begin
        settle_done = (state == S_SETTLE) && (settle_cnt == SETTLE_END);
        run         = EN && ((state == S_ACQ) || (state == S_LOCKED));
        win_last    = (win_idx == WIN_END);
        // A fresh window starts from zero so an edge in its first cycle still counts.
        cnt_base    = (win_idx == '0) ? '0 : edge_cnt;
        // Saturate rather than wrap: a runaway VCO must never look like a good count.
        cnt_now     = (fb_edge && (cnt_base != CNT_MAX)) ? cnt_base + CW'(1) : cnt_base;
        cnt_good    = (int'(cnt_now) >= GOOD_LO) && (int'(cnt_now) <= GOOD_HI);
        gc_inc      = cnt_good ? good_cnt + GW'(1) : '0;
        wc_inc      = win_cnt + NW'(1);
        lock_hit    = (gc_inc == LOCK_GOAL);
        fail_hit    = (wc_inc == WIN_LIMIT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= S_OFF;
            PWRUP_1V8 <= 1'b0;
            LOCK      <= 1'b0;
            FAIL      <= 1'b0;
        end else begin
            state     <= state_next;
            PWRUP_1V8 <= pwrup_d;
            LOCK      <= lock_d;
            FAIL      <= fail_d;
        end
    end

    // Next-state decode; dropping EN beats any event landing in the same cycle.
    always_comb begin
        state_next = state;
        if (!EN) begin
            state_next = S_OFF;
        end else begin
            case (state)
                S_OFF:    state_next = S_SETTLE;
                S_SETTLE: if (settle_done) state_next = S_ACQ;
                S_ACQ: begin
                    // Lock is checked first so it wins over a simultaneous timeout.
                    if (win_last) begin
                        if (lock_hit)      state_next = S_LOCKED;
                        else if (fail_hit) state_next = S_FAIL;
                    end
                end
                S_LOCKED: if (win_last && !cnt_good) state_next = S_ACQ;
                S_FAIL:   state_next = S_FAIL;
                default:  state_next = S_OFF;
            endcase
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        pwrup_d = (state_next == S_SETTLE) || (state_next == S_ACQ) ||
                  (state_next == S_LOCKED);
        lock_d  = (state_next == S_LOCKED);
        fail_d  = (state_next == S_FAIL);
    end

    // Settle timer; idles at zero outside SETTLE so each power-up gets the full wait.
    always_ff @(posedge CK) begin
        if (RST) begin
            settle_cnt <= '0;
        end else if (EN && (state == S_SETTLE)) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Window counter, edge counter and the good/attempt bookkeeping.
    always_ff @(posedge CK) begin
        if (RST) begin
            win_idx  <= '0;
            edge_cnt <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
            CNT_LAST <= '0;
        end else if (!run) begin
            // Held clear outside measurement so ACQ always begins on a window boundary.
            win_idx  <= '0;
            edge_cnt <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
        end else begin
            win_idx  <= win_last ? '0 : win_idx + WW'(1);
            edge_cnt <= cnt_now;
            if (win_last) begin
                CNT_LAST <= cnt_now;
                if (state == S_ACQ) begin
                    good_cnt <= gc_inc;
                    if (!lock_hit) win_cnt <= wc_inc;
                end else if (!cnt_good) begin
                    // Losing lock restarts acquisition with a fresh attempt budget.
                    good_cnt <= '0;
                    win_cnt  <= '0;
                end
            end
        end
    end

    assign STATE = state;

endmodule
